// File: rtl/muldiv_seq_pkg.sv
// Shared constants and types for the sequential HI/LO multiply/divide unit.
package muldiv_seq_pkg;

   localparam int WIDTH = 32;
   localparam int CNT_W = 6;

   localparam logic FT_ADD = 1'b0;
   localparam logic FT_SUB = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ABS_A  = 3'd1,
      ABS_B  = 3'd2,
      ITER   = 3'd3,
      NEG_LO = 3'd4,
      NEG_HI = 3'd5,
      DONE   = 3'd6
   } state_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the EX stage and the multiply/divide sequencer.
interface muldiv_seq_if #(
   parameter int WIDTH = muldiv_seq_pkg::WIDTH
);
   logic             start;
   logic             op_div;
   logic             Signed;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             cancel;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;
   logic             div_by_zero;

   modport master (
      output start, op_div, Signed, A, B, cancel,
      input  busy, done, HI, LO, div_by_zero
   );

   modport slave (
      input  start, op_div, Signed, A, B, cancel,
      output busy, done, HI, LO, div_by_zero
   );
endinterface

// File: rtl/muldiv_seq_arith.sv
// Shared adder/subtractor (FT=1 subtracts) with zero/negative/overflow flags.
module muldiv_seq_arith #(
   parameter int WIDTH = muldiv_seq_pkg::WIDTH
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             FT,
   input  logic             S,
   output logic [WIDTH-1:0] R,
   output logic             Zero,
   output logic             Overflow,
   output logic             Negative
);
   logic [WIDTH-1:0] bx;
   logic [WIDTH:0]   sum;

   assign bx       = FT ? ~B : B;
   assign sum      = {1'b0, A} + {1'b0, bx} + {{WIDTH{1'b0}}, FT};
   assign R        = sum[WIDTH-1:0];
   assign Zero     = (R == '0);
   assign Negative = R[WIDTH-1];
   // Signed: operand signs agree but result sign differs; unsigned: carry-out / borrow.
   assign Overflow = S ? ((A[WIDTH-1] == bx[WIDTH-1]) && (R[WIDTH-1] != A[WIDTH-1]))
                       : (sum[WIDTH] ^ FT);
endmodule

// File: rtl/muldiv_seq.sv
// Fixed-latency MULT/MULTU/DIV/DIVU sequencer; one shared adder handles abs,
// shift-add / shift-subtract iterations and the final sign correction.
module muldiv_seq #(
   parameter int WIDTH = muldiv_seq_pkg::WIDTH,
   parameter int CNT_W = muldiv_seq_pkg::CNT_W
) (
   input logic         clk,
   input logic         reset,
   muldiv_seq_if.slave bus
);
   import muldiv_seq_pkg::*;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, orig_a_q, orig_a_d;
   logic [WIDTH-1:0] hw_q, hw_d, lw_q, lw_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             op_div_q, op_div_d, sgn_q, sgn_d;
   logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d;
   logic             bz_q, bz_d, carry_q, carry_d, dz_q, dz_d;

   logic [WIDTH-1:0] ar_a, ar_b, ar_r;
   logic             ar_ft, ar_zero, ar_neg, ar_ovf_unused;
   logic             a_msb, b_msb, add_c, sub_bw, take, sdiff, hi_fix;

   muldiv_seq_arith #(.WIDTH(WIDTH)) u_arith (
      .A        (ar_a),
      .B        (ar_b),
      .FT       (ar_ft),
      .S        (1'b0),
      .R        (ar_r),
      .Zero     (ar_zero),
      .Overflow (ar_ovf_unused),
      .Negative (ar_neg)
   );

   // Carry/borrow out of the MSB rebuilt from operand and result sign bits.
   assign a_msb  = ar_a[WIDTH-1];
   assign b_msb  = ar_b[WIDTH-1];
   assign add_c  = (a_msb & b_msb) | ((a_msb | b_msb) & ~ar_neg);
   assign sub_bw = (~a_msb & b_msb) | ((~a_msb | b_msb) & ar_neg);
   assign sdiff  = neg_a_q ^ neg_b_q;
   assign take   = hw_q[WIDTH-1] | ~sub_bw;
   assign hi_fix = sgn_q & (op_div_q ? neg_a_q : sdiff);

   always_comb begin
      ar_a  = '0;
      ar_b  = '0;
      ar_ft = FT_ADD;
      case (state_q)
         ABS_A: begin
            ar_b  = a_q;
            ar_ft = FT_SUB;
         end
         ABS_B: begin
            ar_b  = b_q;
            ar_ft = FT_SUB;
         end
         ITER: begin
            ar_a  = op_div_q ? {hw_q[WIDTH-2:0], lw_q[WIDTH-1]} : hw_q;
            ar_b  = b_q;
            ar_ft = op_div_q ? FT_SUB : FT_ADD;
         end
         NEG_LO: begin
            ar_a = ~lw_q;
            ar_b = {{(WIDTH-1){1'b0}}, 1'b1};
         end
         NEG_HI: begin
            ar_a = ~hw_q;
            ar_b = {{(WIDTH-1){1'b0}}, (op_div_q | carry_q)};
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      orig_a_d = orig_a_q;
      hw_d     = hw_q;
      lw_d     = lw_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      op_div_d = op_div_q;
      sgn_d    = sgn_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      bz_d     = bz_q;
      carry_d  = carry_q;
      dz_d     = dz_q;
      if (bus.cancel && state_q != IDLE) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (bus.start) begin
               state_d  = ABS_A;
               a_d      = bus.A;
               b_d      = bus.B;
               orig_a_d = bus.A;
               op_div_d = bus.op_div;
               sgn_d    = bus.Signed;
               neg_a_d  = bus.Signed & bus.A[WIDTH-1];
               neg_b_d  = bus.Signed & bus.B[WIDTH-1];
               bz_d     = (bus.B == '0);
               carry_d  = 1'b0;
               dz_d     = 1'b0;
            end
            ABS_A: begin
               if (neg_a_q) a_d = ar_r;
               state_d = ABS_B;
            end
            ABS_B: begin
               if (neg_b_q) b_d = ar_r;
               hw_d    = '0;
               lw_d    = a_q;
               cnt_d   = '0;
               state_d = ITER;
            end
            ITER: begin
               if (op_div_q) begin
                  hw_d = take ? ar_r : ar_a;
                  lw_d = {lw_q[WIDTH-2:0], take};
               end else if (lw_q[0]) begin
                  {hw_d, lw_d} = {add_c, ar_r, lw_q[WIDTH-1:1]};
               end else begin
                  {hw_d, lw_d} = {1'b0, hw_q, lw_q[WIDTH-1:1]};
               end
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH-1)) state_d = NEG_LO;
            end
            NEG_LO: begin
               // Zero result of ~LO+1 means LO was 0, i.e. the carry into HI.
               if (sgn_q & sdiff) begin
                  lw_d    = ar_r;
                  carry_d = ar_zero;
               end
               state_d = NEG_HI;
            end
            NEG_HI: begin
               if (hi_fix) hw_d = ar_r;
               if (op_div_q & bz_q) begin
                  hi_d = orig_a_q;
                  lo_d = '1;
                  dz_d = 1'b1;
               end else begin
                  hi_d = hw_d;
                  lo_d = lw_q;
               end
               state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         orig_a_q <= '0;
         hw_q     <= '0;
         lw_q     <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         op_div_q <= 1'b0;
         sgn_q    <= 1'b0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         bz_q     <= 1'b0;
         carry_q  <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         orig_a_q <= orig_a_d;
         hw_q     <= hw_d;
         lw_q     <= lw_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         op_div_q <= op_div_d;
         sgn_q    <= sgn_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         bz_q     <= bz_d;
         carry_q  <= carry_d;
         dz_q     <= dz_d;
      end
   end

   assign bus.busy        = (state_q != IDLE);
   assign bus.done        = (state_q == DONE);
   assign bus.HI          = hi_q;
   assign bus.LO          = lo_q;
   assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed + random checks of muldiv_seq against a plain-arithmetic reference.
module tb_muldiv_seq;
   logic clk;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   muldiv_seq_if bus ();

   muldiv_seq dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Returns {div_by_zero, HI, LO} from the architectural definition.
   function automatic logic [64:0] model(input bit d, input bit s,
                                         input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, q, r;
      logic [63:0]     p;
      logic [31:0]     uq, ur;
      if (d && b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
      if (!d) begin
         if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            p  = 64'(sa * sb);
         end else begin
            p = {32'd0, a} * {32'd0, b};
         end
         return {1'b0, p};
      end
      if (s) begin
         sa = $signed(a);
         sb = $signed(b);
         q  = sa / sb;
         r  = sa % sb;
         return {1'b0, r[31:0], q[31:0]};
      end
      uq = a / b;
      ur = a % b;
      return {1'b0, ur, uq};
   endfunction

   task automatic count_dones(input string tag, input int cycles);
      int n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (bus.done) n++;
      end
      check(tag, 64'(n), 64'd0);
   endtask

   task automatic run_op(input string tag, input bit d, input bit s,
                         input logic [31:0] a, input logic [31:0] b, input bit poke);
      logic [64:0] e;
      int          n;
      bit          got;
      e = model(d, s, a, b);
      @(negedge clk);
      bus.start = 1'b1; bus.op_div = d; bus.Signed = s; bus.A = a; bus.B = b;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
      bus.op_div = ~d; bus.Signed = ~s;
      check({tag, "_busy"}, 64'(bus.busy), 64'd1);
      n = 0; got = 1'b0;
      while (n < 60 && !got) begin
         @(posedge clk); n++; #1;
         if (poke && n == 5) begin
            bus.start = 1'b1; bus.A = 32'd9; bus.B = 32'd3;
         end
         if (poke && n == 6) bus.start = 1'b0;
         got = bus.done;
      end
      check({tag, "_lat"}, 64'(n), 64'd36);
      check({tag, "_hi"}, 64'(bus.HI), 64'(e[63:32]));
      check({tag, "_lo"}, 64'(bus.LO), 64'(e[31:0]));
      check({tag, "_dz"}, 64'(bus.div_by_zero), 64'(e[64]));
      @(posedge clk); #1;
      check({tag, "_pulse"}, {62'd0, bus.done, bus.busy}, 64'd0);
      if (poke) count_dones({tag, "_extra"}, 45);
   endtask

   initial begin
      logic [31:0] ph, pl, ra, rb;
      bit          rd, rs;
      int          sel;
      reset = 1'b0;
      bus.start = 1'b0; bus.op_div = 1'b0; bus.Signed = 1'b0;
      bus.A = '0; bus.B = '0; bus.cancel = 1'b0;
      #1;
      check("rst_outs", {bus.HI, bus.LO}, 64'd0);
      check("rst_flags", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
      #22 reset = 1'b1;

      run_op("multu_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op("mult_m3x7", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, 1'b0);
      run_op("mult_min2", 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
      run_op("div_m7_2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op("divu_100_7", 1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
      run_op("divu_by0", 1'b1, 1'b0, 32'd5, 32'd0, 1'b0);
      run_op("multu_2x3", 1'b0, 1'b0, 32'd2, 32'd3, 1'b0);
      run_op("div_ovf_poke", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

      // Cancel once the iteration counter has reached 10.
      ph = bus.HI; pl = bus.LO;
      @(negedge clk);
      bus.start = 1'b1; bus.op_div = 1'b0; bus.Signed = 1'b0;
      bus.A = 32'h1234_5678; bus.B = 32'h9ABC_DEF0;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (12) @(posedge clk);
      #1 bus.cancel = 1'b1;
      @(posedge clk); #1 bus.cancel = 1'b0;
      check("cancel_idle", {62'd0, bus.busy, bus.done}, 64'd0);
      check("cancel_hold", {bus.HI, bus.LO}, {ph, pl});
      count_dones("cancel_nodone", 45);

      // Reset mid-iteration.
      @(negedge clk);
      bus.start = 1'b1; bus.op_div = 1'b1; bus.Signed = 1'b0;
      bus.A = 32'd1000; bus.B = 32'd3;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (15) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("midrst_outs", {bus.HI, bus.LO}, 64'd0);
      check("midrst_flags", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
      @(negedge clk) reset = 1'b1;

      for (int i = 0; i < 16; i++) begin
         rd  = 1'($urandom_range(0, 1));
         rs  = 1'($urandom_range(0, 1));
         ra  = $urandom;
         rb  = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) rb = 32'd0;
         if (sel == 1) rb = rb >> $urandom_range(16, 31);
         if (sel == 2) ra = 32'h8000_0000;
         run_op($sformatf("rand%0d", i), rd, rs, ra, rb, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
